// File: rtl/ti_sbox_nibble_seq.sv
// ti_sbox_nibble_seq: sequencer for the nibble-serial, multi-stage
// threshold-implementation S-box datapath. It streams NIBBLES indices
// through the pipeline and requests one fresh random word per nibble. The
// whole pipeline freezes for any cycle in which that random word is late.
// Optional build macro: TI_SEQ_PERF_EN adds the stall_cnt_o counter.
module ti_sbox_nibble_seq #(
   parameter int NIBBLES = 16,
   parameter int STAGES  = 2,
   parameter int IDX_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              clear_i,
   input  logic              rnd_valid_i,
   output logic              rnd_req_o,
   output logic [IDX_W-1:0]  rd_idx_o,
   output logic [STAGES-1:0] stg_en_o,
   output logic              wr_en_o,
   output logic [IDX_W-1:0]  wr_idx_o,
   output logic              busy_o,
   output logic              done_o
`ifdef TI_SEQ_PERF_EN
   ,
   output logic [15:0]       stall_cnt_o
`endif
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);
   localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state, state_nxt;
   logic [STAGES-1:0] vld;     // occupancy of each TI share register stage
   logic              issue;   // a nibble enters stage 0 this cycle
   logic              adv;     // whole pipeline moves one step this cycle

   // State register; reset drops straight to IDLE without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; clear_i overrides everything, including start_i.
   always_comb begin
      state_nxt = state;
      if (clear_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start_i) state_nxt = RUN;
            RUN:     if (issue && rd_idx_o == LAST) state_nxt = DRAIN;
            DRAIN:   if (wr_en_o && wr_idx_o == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Output decode; in RUN a missing random word stalls every stage at once.
   always_comb begin
      rnd_req_o   = (state == RUN);
      issue       = rnd_req_o & rnd_valid_i;
      adv         = (state == RUN) ? issue : (state == DRAIN);
      stg_en_o    = '0;
      stg_en_o[0] = issue;
      for (int k = 1; k < STAGES; k++) begin
         stg_en_o[k] = adv & vld[k-1];
      end
      wr_en_o = adv & vld[STAGES-1];
      busy_o  = (state == RUN) | (state == DRAIN);
      done_o  = (state == DONE);
   end

   // Occupancy shift register and read/write index counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld      <= '0;
         rd_idx_o <= '0;
         wr_idx_o <= '0;
      end else if (clear_i) begin
         vld      <= '0;
         rd_idx_o <= '0;
         wr_idx_o <= '0;
      end else begin
         if (adv) begin
            vld[0] <= issue;
            for (int k = 1; k < STAGES; k++) begin
               vld[k] <= vld[k-1];
            end
         end
         if (issue) rd_idx_o <= (rd_idx_o == LAST) ? '0 : rd_idx_o + ONE;
         if (wr_en_o) wr_idx_o <= (wr_idx_o == LAST) ? '0 : wr_idx_o + ONE;
      end
   end

`ifdef TI_SEQ_PERF_EN
   // Saturating count of RUN cycles spent waiting for randomness.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_o <= '0;
      end else if (state == IDLE && start_i && !clear_i) begin
         stall_cnt_o <= '0;
      end else if (rnd_req_o && !rnd_valid_i && stall_cnt_o != 16'hFFFF) begin
         stall_cnt_o <= stall_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ti_sbox_nibble_seq.sv
// tb_ti_sbox_nibble_seq: directed timing scenarios plus randomized traffic,
// compared cycle by cycle against a nibble-level pipeline model.
module tb_ti_sbox_nibble_seq;

   localparam int NIBBLES = 16;
   localparam int STAGES  = 2;
   localparam int IDX_W   = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start_i = 1'b0;
   logic              clear_i = 1'b0;
   logic              rnd_valid_i = 1'b0;
   logic              rnd_req_o;
   logic [IDX_W-1:0]  rd_idx_o;
   logic [STAGES-1:0] stg_en_o;
   logic              wr_en_o;
   logic [IDX_W-1:0]  wr_idx_o;
   logic              busy_o;
   logic              done_o;
`ifdef TI_SEQ_PERF_EN
   logic [15:0]       stall_cnt_o;
`endif

   ti_sbox_nibble_seq #(.NIBBLES(NIBBLES), .STAGES(STAGES), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i),
      .rnd_valid_i(rnd_valid_i), .rnd_req_o(rnd_req_o), .rd_idx_o(rd_idx_o),
      .stg_en_o(stg_en_o), .wr_en_o(wr_en_o), .wr_idx_o(wr_idx_o),
      .busy_o(busy_o), .done_o(done_o)
`ifdef TI_SEQ_PERF_EN
      , .stall_cnt_o(stall_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: in-flight nibble numbers per pipeline slot (-1 = empty).
   bit m_active, m_done;
   int m_issued, m_written, m_stall;
   int pipe [STAGES];

   task automatic m_reset();
      m_active = 0; m_done = 0; m_issued = 0; m_written = 0; m_stall = 0;
      for (int k = 0; k < STAGES; k++) pipe[k] = -1;
   endtask

   // Per-test statistics taken from the observed DUT outputs.
   int cyc, done_cnt, done_cyc, wr_cnt, first_wr, last_wr, busy_cnt, first_busy;
   int iss_cnt, first_iss, en_in_stall;
   logic [IDX_W-1:0] obs_rd;

   task automatic clr_stats();
      cyc = 0; done_cnt = 0; done_cyc = -1; wr_cnt = 0; first_wr = -1; last_wr = -1;
      busy_cnt = 0; first_busy = -1; iss_cnt = 0; first_iss = -1; en_in_stall = 0;
   endtask

   function automatic logic [31:0] pack_dut();
      return 32'({rnd_req_o, rd_idx_o, stg_en_o, wr_en_o, wr_idx_o, busy_o, done_o});
   endfunction

   // One clock cycle: compare at the falling edge, advance model at the rising edge.
   task automatic step();
      bit e_req, e_issue, e_adv, e_wr, fin;
      logic [STAGES-1:0] e_stg;
      logic [IDX_W-1:0] e_rd, e_wri;
      e_req   = m_active && (m_issued < NIBBLES);
      e_issue = e_req && rnd_valid_i;
      e_adv   = e_req ? e_issue : m_active;
      e_stg   = '0;
      e_stg[0] = e_issue;
      for (int k = 1; k < STAGES; k++) e_stg[k] = e_adv && (pipe[k-1] >= 0);
      e_wr  = e_adv && (pipe[STAGES-1] >= 0);
      e_rd  = IDX_W'(m_issued % NIBBLES);
      e_wri = IDX_W'(m_written % NIBBLES);
      @(negedge clk);
      chk("cycle_outputs", pack_dut(),
          32'({e_req, e_rd, e_stg, e_wr, e_wri, m_active, m_done}));
`ifdef TI_SEQ_PERF_EN
      chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
`endif
      obs_rd = rd_idx_o;
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      if (wr_en_o) begin if (first_wr < 0) first_wr = cyc; last_wr = cyc; wr_cnt++; end
      if (busy_o) begin if (first_busy < 0) first_busy = cyc; busy_cnt++; end
      if (stg_en_o[0]) begin if (first_iss < 0) first_iss = cyc; iss_cnt++; end
      if (cyc >= 5 && cyc <= 7 && (stg_en_o != '0 || wr_en_o)) en_in_stall++;
      @(posedge clk);
      if (e_req && !rnd_valid_i && m_stall < 65535) m_stall++;
      if (clear_i) begin
         m_active = 0; m_done = 0; m_issued = 0; m_written = 0;
         for (int k = 0; k < STAGES; k++) pipe[k] = -1;
      end else begin
         fin = e_wr && (pipe[STAGES-1] == NIBBLES - 1);
         if (m_done) m_done = 0;
         else if (!m_active && start_i) begin
            m_active = 1; m_issued = 0; m_written = 0; m_stall = 0;
         end
         if (e_adv) begin
            for (int k = STAGES - 1; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = e_issue ? m_issued : -1;
         end
         if (e_issue) m_issued++;
         if (e_wr) m_written++;
         if (fin) begin m_active = 0; m_done = 1; end
      end
      cyc++;
      #1;
   endtask

   initial begin
      m_reset();
      clr_stats();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", pack_dut(), 32'd0);
      rst = 1'b0;

      // T1: uninterrupted run
      clr_stats();
      for (int c = 0; c < 25; c++) begin
         start_i = (c == 0); rnd_valid_i = 1'b1; step();
      end
      start_i = 1'b0;
      chk("t1_first_issue", 32'(first_iss), 32'd1);
      chk("t1_issues", 32'(iss_cnt), 32'd16);
      chk("t1_first_wr", 32'(first_wr), 32'd3);
      chk("t1_last_wr", 32'(last_wr), 32'd18);
      chk("t1_wr_cnt", 32'(wr_cnt), 32'd16);
      chk("t1_done_cnt", 32'(done_cnt), 32'd1);
      chk("t1_done_cyc", 32'(done_cyc), 32'd19);
      chk("t1_first_busy", 32'(first_busy), 32'd1);
      chk("t1_busy_cnt", 32'(busy_cnt), 32'd18);

      // T2: randomness late in cycles 5..7
      clr_stats();
      for (int c = 0; c < 30; c++) begin
         start_i = (c == 0); rnd_valid_i = !(c >= 5 && c <= 7); step();
         if (c == 6) chk("t2_rd_hold", 32'(obs_rd), 32'd4);
      end
      start_i = 1'b0;
      chk("t2_en_in_stall", 32'(en_in_stall), 32'd0);
      chk("t2_done_cyc", 32'(done_cyc), 32'd22);
`ifdef TI_SEQ_PERF_EN
      chk("t2_stall_cnt", 32'(stall_cnt_o), 32'd3);
`endif

      // T3: second start during RUN is ignored
      clr_stats();
      for (int c = 0; c < 30; c++) begin
         start_i = (c == 0 || c == 4); rnd_valid_i = 1'b1; step();
      end
      start_i = 1'b0;
      chk("t3_done_cnt", 32'(done_cnt), 32'd1);
      chk("t3_wr_cnt", 32'(wr_cnt), 32'd16);

      // T4: clear with start at cycle 10, then a clean restart
      clr_stats();
      for (int c = 0; c < 20; c++) begin
         start_i = (c == 0 || c == 10); clear_i = (c == 10); rnd_valid_i = 1'b1; step();
         if (c == 11) chk("t4_busy_after_clear", 32'(busy_o), 32'd0);
      end
      start_i = 1'b0; clear_i = 1'b0;
      chk("t4_no_done", 32'(done_cnt), 32'd0);
      clr_stats();
      for (int c = 0; c < 25; c++) begin
         start_i = (c == 0); step();
         if (c == 1) chk("t4_restart_rd", 32'(obs_rd), 32'd0);
      end
      start_i = 1'b0;
      chk("t4_restart_done_cyc", 32'(done_cyc), 32'd19);
      chk("t4_restart_wr_cnt", 32'(wr_cnt), 32'd16);

      // T5: asynchronous reset in the middle of a DRAIN cycle
      clr_stats();
      for (int c = 0; c < 17; c++) begin
         start_i = (c == 0); rnd_valid_i = 1'b1; step();
      end
      start_i = 1'b0;
      chk("t5_in_drain", 32'({busy_o, rnd_req_o}), 32'b10);
      #2 rst = 1'b1;
      #1 chk("t5_async_reset", pack_dut(), 32'd0);
      m_reset();
      @(posedge clk); #1 rst = 1'b0;
      clr_stats();
      for (int c = 0; c < 30; c++) step();
      chk("t5_no_done", 32'(done_cnt), 32'd0);

`ifdef TI_SEQ_PERF_EN
      // T6: long starvation saturates the stall counter
      clr_stats();
      start_i = 1'b1; rnd_valid_i = 1'b0; step();
      start_i = 1'b0;
      for (int c = 0; c < 70000; c++) step();
      chk("t6_stall_sat", 32'(stall_cnt_o), 32'hFFFF);
      rnd_valid_i = 1'b1;
      for (int c = 0; c < 25; c++) step();
      chk("t6_done_cnt", 32'(done_cnt), 32'd1);
      chk("t6_stall_held", 32'(stall_cnt_o), 32'hFFFF);
`endif

      // Randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         start_i     = ($urandom_range(0, 7) == 0);
         clear_i     = ($urandom_range(0, 99) == 0);
         rnd_valid_i = ($urandom_range(0, 3) != 0);
         step();
      end
      start_i = 1'b0; clear_i = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
